// File: rtl/coordinate_transform_pipe_pkg.sv
// Shared types and elaboration-time scale-constant math for the pyramid
// coordinate transformer.
`timescale 1ns/1ps
package coord_xform_pkg;

  typedef struct packed {
    logic [7:0] octave;
    logic [7:0] sublevel;
  } level_t;

  function automatic int unsigned scale_width(input int unsigned frac_bits,
                                              input int unsigned octaves);
    return frac_bits + octaves + 1;
  endfunction

  localparam int unsigned KW = scale_width(16, 4);

  // round(2^frac_bits * 2^(+/-s)), s = octave + sublevel/levels; elaboration only
  function automatic longint unsigned scale_const(input int unsigned octave,
                                                  input int unsigned sublevel,
                                                  input int unsigned levels,
                                                  input bit          inverse,
                                                  input int unsigned frac_bits);
    real s;
    real e;
    real v;
    s = real'(octave) + real'(sublevel) / real'(levels);
    e = inverse ? s : -s;
    v = (2.0 ** real'(frac_bits)) * (2.0 ** e);
    return longint'($floor(v + 0.5));
  endfunction

endpackage

// File: rtl/coordinate_transform_pipe_lane.sv
// One coordinate channel: S2 multiply, S3 round-half-up and saturate.
`timescale 1ns/1ps
module coord_scale_lane #(
  parameter int unsigned COORD_BITS = 16,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned SCALE_W    = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SCALE_W-1:0]    k,
  input  logic [COORD_BITS-1:0] coord,
  output logic [COORD_BITS-1:0] result,
  output logic                  sat
);

  localparam int unsigned PW = COORD_BITS + SCALE_W;
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_BITS - 1);

  logic [PW-1:0] p_q;
  logic [PW-1:0] rounded;
  logic [PW-1:0] shifted;
  logic          ovf;

  // Max product plus HALF still fits in PW bits, so no carry is lost.
  always_comb begin
    rounded = p_q + HALF;
    shifted = rounded >> FRAC_BITS;
    ovf     = |shifted[PW-1:COORD_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else if (en) begin
      p_q    <= PW'(coord) * PW'(k);
      result <= ovf ? '1 : shifted[COORD_BITS-1:0];
      sat    <= ovf;
    end
  end

endmodule

// File: rtl/coordinate_transform_pipe.sv
// Three-stage valid/ready pipeline mapping (x,y) between base image and a
// selectable pyramid level, in either direction.
`timescale 1ns/1ps
module coordinate_transform_pipe
  import coord_xform_pkg::*;
#(
  parameter int unsigned COORD_BITS        = 16,
  parameter int unsigned OCTAVES           = 4,
  parameter int unsigned LEVELS_PER_OCTAVE = 3,
  parameter int unsigned FRAC_BITS         = 16,
  parameter int unsigned TAG_BITS          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [COORD_BITS-1:0]                in_x,
  input  logic [COORD_BITS-1:0]                in_y,
  input  logic [$clog2(OCTAVES)-1:0]           in_octave,
  input  logic [$clog2(LEVELS_PER_OCTAVE)-1:0] in_sublevel,
  input  logic                                 in_inverse,
  input  logic [TAG_BITS-1:0]                  in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [COORD_BITS-1:0]                out_x,
  output logic [COORD_BITS-1:0]                out_y,
  output logic [TAG_BITS-1:0]                  out_tag,
  output logic                                 out_sat,
  output logic                                 out_err
);

  localparam int unsigned SCALE_W    = scale_width(FRAC_BITS, OCTAVES);
  localparam int unsigned NUM_LEVELS = OCTAVES * LEVELS_PER_OCTAVE;
  localparam int unsigned IDX_W      = $clog2(NUM_LEVELS);

  logic [SCALE_W-1:0] rom_fwd [NUM_LEVELS];
  logic [SCALE_W-1:0] rom_inv [NUM_LEVELS];

  for (genvar o = 0; o < OCTAVES; o++) begin : g_oct
    for (genvar l = 0; l < LEVELS_PER_OCTAVE; l++) begin : g_lvl
      localparam logic [SCALE_W-1:0] K_FWD =
        SCALE_W'(scale_const(o, l, LEVELS_PER_OCTAVE, 1'b0, FRAC_BITS));
      localparam logic [SCALE_W-1:0] K_INV =
        SCALE_W'(scale_const(o, l, LEVELS_PER_OCTAVE, 1'b1, FRAC_BITS));
      assign rom_fwd[o*LEVELS_PER_OCTAVE + l] = K_FWD;
      assign rom_inv[o*LEVELS_PER_OCTAVE + l] = K_INV;
    end
  end

  logic               en;
  level_t             lvl;
  logic               lvl_bad;
  logic [IDX_W-1:0]   rom_idx;
  logic [SCALE_W-1:0] k_sel;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // An illegal level selects K=0, which forces zero outputs and no saturation.
  always_comb begin
    lvl          = '0;
    lvl.octave   = 8'(in_octave);
    lvl.sublevel = 8'(in_sublevel);
    lvl_bad      = (32'(lvl.octave) >= OCTAVES) ||
                   (32'(lvl.sublevel) >= LEVELS_PER_OCTAVE);
    rom_idx      = '0;
    k_sel        = '0;
    if (!lvl_bad) begin
      rom_idx = IDX_W'(32'(lvl.octave) * LEVELS_PER_OCTAVE + 32'(lvl.sublevel));
      k_sel   = in_inverse ? rom_inv[rom_idx] : rom_fwd[rom_idx];
    end
  end

  logic                  v1, v2;
  logic [COORD_BITS-1:0] x1, y1;
  logic [SCALE_W-1:0]    k1;
  logic [TAG_BITS-1:0]   tag1, tag2;
  logic                  err1, err2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      y1        <= '0;
      k1        <= '0;
      tag1      <= '0;
      tag2      <= '0;
      out_tag   <= '0;
      err1      <= 1'b0;
      err2      <= 1'b0;
      out_err   <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      x1        <= in_x;
      y1        <= in_y;
      k1        <= k_sel;
      tag1      <= in_tag;
      err1      <= lvl_bad;
      v2        <= v1;
      tag2      <= tag1;
      err2      <= err1;
      out_valid <= v2;
      out_tag   <= tag2;
      out_err   <= err2;
    end
  end

  logic sat_x, sat_y;

  coord_scale_lane #(
    .COORD_BITS(COORD_BITS),
    .FRAC_BITS (FRAC_BITS),
    .SCALE_W   (SCALE_W)
  ) u_lane_x (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .k     (k1),
    .coord (x1),
    .result(out_x),
    .sat   (sat_x)
  );

  coord_scale_lane #(
    .COORD_BITS(COORD_BITS),
    .FRAC_BITS (FRAC_BITS),
    .SCALE_W   (SCALE_W)
  ) u_lane_y (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .k     (k1),
    .coord (y1),
    .result(out_y),
    .sat   (sat_y)
  );

  assign out_sat = sat_x | sat_y;

endmodule

// File: tb/tb_coordinate_transform_pipe.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and
// compares on every output handshake and checks stability while stalled.
`timescale 1ns/1ps
module tb_coordinate_transform_pipe;

  localparam int unsigned CB  = 16;
  localparam int unsigned OCT = 4;
  localparam int unsigned LPO = 3;
  localparam int unsigned FB  = 16;
  localparam int unsigned TW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CB-1:0] in_x, in_y;
  logic [1:0]    in_octave;
  logic [1:0]    in_sublevel;
  logic          in_inverse;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [CB-1:0] out_x, out_y;
  logic [TW-1:0] out_tag;
  logic          out_sat;
  logic          out_err;

  coordinate_transform_pipe #(
    .COORD_BITS       (CB),
    .OCTAVES          (OCT),
    .LEVELS_PER_OCTAVE(LPO),
    .FRAC_BITS        (FB),
    .TAG_BITS         (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_octave  (in_octave),
    .in_sublevel(in_sublevel),
    .in_inverse (in_inverse),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_tag    (out_tag),
    .out_sat    (out_sat),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x;
    longint y;
    longint tag;
    bit     sat;
    bit     err;
    longint acc;
    bit     chk_lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  longint      cyc      = 0;
  int unsigned ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: scale by 2^(+/-s) in real arithmetic, round half up, clamp.
  function automatic exp_t model(input int unsigned x, input int unsigned y,
                                 input int unsigned oct, input int unsigned sub,
                                 input bit inv, input int unsigned tag);
    exp_t   e;
    real    s, kr;
    longint k, rx, ry;
    e = '{x: 0, y: 0, tag: tag, sat: 1'b0, err: 1'b0, acc: 0, chk_lat: 1'b0};
    if (oct >= OCT || sub >= LPO) begin
      e.err = 1'b1;
      return e;
    end
    s  = real'(oct) + real'(sub) / 3.0;
    kr = 65536.0 * (inv ? (2.0 ** s) : (2.0 ** (-s)));
    k  = longint'($floor(kr + 0.5));
    rx = (longint'(x) * k + 32768) / 65536;
    ry = (longint'(y) * k + 32768) / 65536;
    e.sat = (rx > 65535) || (ry > 65535);
    e.x   = (rx > 65535) ? 65535 : rx;
    e.y   = (ry > 65535) ? 65535 : ry;
    return e;
  endfunction

  task automatic send(input int unsigned x, input int unsigned y,
                      input int unsigned oct, input int unsigned sub,
                      input bit inv, input int unsigned tag,
                      input bit directed, input longint ex, input longint ey,
                      input bit es, input bit ee, input bit lat);
    exp_t        e;
    int unsigned w = 0;
    bit          ok = 1'b1;
    in_valid    = 1'b1;
    in_x        = CB'(x);
    in_y        = CB'(y);
    in_octave   = 2'(oct);
    in_sublevel = 2'(sub);
    in_inverse  = inv;
    in_tag      = TW'(tag);
    if (directed)
      e = '{x: ex, y: ey, tag: tag, sat: es, err: ee, acc: 0, chk_lat: 1'b0};
    else
      e = model(x, y, oct, sub, inv, tag);
    e.chk_lat = lat;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    idle(4);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  logic [CB-1:0] hx, hy;
  logic [TW-1:0] htag;
  logic          hs, he;
  bit            hold = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold)
        chk("hold_stable", {out_valid, out_x, out_y, out_tag, out_sat, out_err},
            {1'b1, hx, hy, htag, hs, he});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got tag 0x%0h x %0d expected no output", out_tag, out_x);
        end else begin
          e = sb.pop_front();
          chk("out_x",   64'(out_x),   64'(e.x));
          chk("out_y",   64'(out_y),   64'(e.y));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_sat", 64'(out_sat), 64'(e.sat));
          chk("out_err", 64'(out_err), 64'(e.err));
          if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'd3);
        end
      end
      hold = out_valid && !out_ready;
      hx   = out_x;
      hy   = out_y;
      htag = out_tag;
      hs   = out_sat;
      he   = out_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0; in_y = '0; in_octave = '0; in_sublevel = '0;
    in_inverse = 1'b0; in_tag = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", {out_x, out_y, out_tag, out_sat, out_err}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    idle(1);

    send(1234, 25, 0, 0, 0, 8'h11, 1, 1234, 25, 0, 0, 1);
    send(25, 7, 1, 0, 0, 8'h12, 1, 13, 4, 0, 0, 1);
    send(100, 0, 0, 1, 0, 8'h13, 1, 79, 0, 0, 0, 1);
    send(25, 3, 1, 0, 1, 8'h14, 1, 50, 6, 0, 0, 1);
    send(9000, 10, 3, 0, 1, 8'h15, 1, 65535, 80, 1, 0, 1);
    send(77, 88, 0, 3, 0, 8'hA5, 1, 0, 0, 0, 1, 1);
    wait_drain();

    ready_mode = 1;
    for (int i = 0; i < 11; i++)
      send($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 3),
           $urandom_range(0, 2), 1'($urandom_range(0, 1)), 8'(8'h40 + i), 0, 0, 0, 0, 0, 0);
    wait_drain();

    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 65535), $urandom_range(0, 4000), $urandom_range(0, 3),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
           0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    wait_drain();
    ready_mode = 0;
    idle(2);

    send(1, 1, 0, 0, 0, 8'h61, 0, 0, 0, 0, 0, 0);
    send(2, 2, 0, 0, 0, 8'h62, 0, 0, 0, 0, 0, 0);
    send(3, 3, 0, 0, 0, 8'h63, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", {out_x, out_y, out_tag, out_sat, out_err}, 64'd0);
    sb.delete();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("postreset_in_ready", 64'(in_ready), 64'd1);
    idle(1);
    send(8, 0, 2, 0, 0, 8'h77, 1, 2, 0, 0, 0, 1);
    wait_drain();
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
